// File: rtl/pc_branch_unit_pkg.sv
// Shared encodings for the PC / control-flow unit: branch, jump and trap-cause
// codes plus the FSM states.
package pc_branch_unit_pkg;

  typedef enum logic [2:0] {
    BRANCH_NONE = 3'd0,
    BRANCH_EQ   = 3'd1,
    BRANCH_NE   = 3'd2,
    BRANCH_LT   = 3'd3,
    BRANCH_GE   = 3'd4,
    BRANCH_LTU  = 3'd5,
    BRANCH_GEU  = 3'd6
  } branch_type_e;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'd0,
    JUMP_JAL  = 2'd1,
    JUMP_JALR = 2'd2
  } jump_type_e;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_EXTERNAL   = 2'd2
  } cause_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pc_branch_unit_compare.sv
// Combinational branch condition evaluator; undefined codes never take.
module branch_compare
  import pc_branch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [2:0]      branch_type,
  output logic            taken_cond
);

  always_comb begin
    taken_cond = 1'b0;
    case (branch_type)
      BRANCH_EQ:  taken_cond = (rs1_data == rs2_data);
      BRANCH_NE:  taken_cond = (rs1_data != rs2_data);
      BRANCH_LT:  taken_cond = ($signed(rs1_data) <  $signed(rs2_data));
      BRANCH_GE:  taken_cond = ($signed(rs1_data) >= $signed(rs2_data));
      BRANCH_LTU: taken_cond = (rs1_data <  rs2_data);
      BRANCH_GEU: taken_cond = (rs1_data >= rs2_data);
      default:    taken_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Architectural PC owner: sequential advance, branch/JAL/JALR redirect,
// misaligned-target and external traps, and a post-redirect flush window.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int              FLUSH_CYCLES = 1,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            step,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] immediate,
  input  logic [2:0]      branch_type,
  input  logic [1:0]      jump_type,
  input  logic            trap_request,
  input  logic            trap_return,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_address,
  output logic            taken,
  output logic            busy,
  output logic [XLEN-1:0] epc,
  output logic [1:0]      cause
);

  // Every redirect lands here; with no flush window we simply stay in RUN.
  localparam state_e     REDIR_STATE = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_RUN;
  localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES);

  state_e          state, state_n;
  logic [3:0]      flush_cnt, flush_cnt_n;
  logic [XLEN-1:0] pc_n, link_n, epc_n;
  logic [1:0]      cause_n;
  logic            taken_n;

  logic            taken_cond, is_jump, redirect, misaligned;
  logic [XLEN-1:0] pc_plus4, target;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .branch_type(branch_type),
    .taken_cond (taken_cond)
  );

  assign pc_plus4   = pc + XLEN'(4);
  assign is_jump    = (jump_type != JUMP_NONE);
  assign redirect   = is_jump || taken_cond;
  assign target     = (jump_type == JUMP_JALR) ? ((rs1_data + immediate) & ~XLEN'(1))
                                               : (pc + immediate);
  assign misaligned = |target[ALIGN_BITS-1:0];
  assign busy       = (state == ST_FLUSH);

  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    pc_n        = pc;
    link_n      = link_address;
    epc_n       = epc;
    cause_n     = cause;
    taken_n     = 1'b0;
    if (trap_request) begin
      epc_n       = pc;
      cause_n     = CAUSE_EXTERNAL;
      pc_n        = TRAP_VECTOR;
      taken_n     = 1'b1;
      state_n     = REDIR_STATE;
      flush_cnt_n = FLUSH_LOAD;
    end else if (trap_return) begin
      pc_n        = epc;
      cause_n     = CAUSE_NONE;
      taken_n     = 1'b1;
      state_n     = REDIR_STATE;
      flush_cnt_n = FLUSH_LOAD;
    end else if (state == ST_FLUSH) begin
      flush_cnt_n = flush_cnt - 4'd1;
      if (flush_cnt == 4'd1) state_n = ST_RUN;
    end else if (step) begin
      if (!redirect) begin
        pc_n = pc_plus4;
      end else begin
        taken_n     = 1'b1;
        state_n     = REDIR_STATE;
        flush_cnt_n = FLUSH_LOAD;
        if (!misaligned) begin
          pc_n = target;
          if (is_jump) link_n = pc_plus4;
        end else begin
          pc_n    = TRAP_VECTOR;
          epc_n   = pc;
          cause_n = CAUSE_MISALIGNED;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_RUN;
      flush_cnt    <= '0;
      pc           <= RESET_VECTOR;
      link_address <= '0;
      epc          <= '0;
      cause        <= CAUSE_NONE;
      taken        <= 1'b0;
    end else begin
      state        <= state_n;
      flush_cnt    <= flush_cnt_n;
      pc           <= pc_n;
      link_address <= link_n;
      epc          <= epc_n;
      cause        <= cause_n;
      taken        <= taken_n;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: three differently-configured instances share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_pc_branch_unit;
  import pc_branch_unit_pkg::*;

  localparam int N = 3;

  logic        clock = 1'b0;
  logic        reset, step, trap_request, trap_return;
  logic [31:0] rs1, rs2, imm;
  logic [2:0]  bt;
  logic [1:0]  jt;

  logic [31:0] pc_o[N], link_o[N], epc_o[N];
  logic        taken_o[N], busy_o[N];
  logic [1:0]  cause_o[N];

  // Per-instance configuration, mirrored in the instantiations below.
  int          fc[N] = '{1, 3, 0};
  int          ab[N] = '{2, 1, 2};
  logic [31:0] rv[N] = '{32'h0, 32'h0, 32'h200};
  logic [31:0] tv[N] = '{32'h100, 32'h100, 32'h80};

  logic [31:0] m_pc[N], m_link[N], m_epc[N];
  logic [1:0]  m_cause[N];
  bit          m_taken[N];
  int          m_wait[N];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  always #5 clock = ~clock;

  pc_branch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
                   .FLUSH_CYCLES(1), .ALIGN_BITS(2)) u_a (
    .clock(clock), .reset(reset), .step(step), .rs1_data(rs1), .rs2_data(rs2),
    .immediate(imm), .branch_type(bt), .jump_type(jt), .trap_request(trap_request),
    .trap_return(trap_return), .pc(pc_o[0]), .link_address(link_o[0]),
    .taken(taken_o[0]), .busy(busy_o[0]), .epc(epc_o[0]), .cause(cause_o[0]));

  pc_branch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
                   .FLUSH_CYCLES(3), .ALIGN_BITS(1)) u_b (
    .clock(clock), .reset(reset), .step(step), .rs1_data(rs1), .rs2_data(rs2),
    .immediate(imm), .branch_type(bt), .jump_type(jt), .trap_request(trap_request),
    .trap_return(trap_return), .pc(pc_o[1]), .link_address(link_o[1]),
    .taken(taken_o[1]), .busy(busy_o[1]), .epc(epc_o[1]), .cause(cause_o[1]));

  pc_branch_unit #(.XLEN(32), .RESET_VECTOR(32'h200), .TRAP_VECTOR(32'h80),
                   .FLUSH_CYCLES(0), .ALIGN_BITS(2)) u_c (
    .clock(clock), .reset(reset), .step(step), .rs1_data(rs1), .rs2_data(rs2),
    .immediate(imm), .branch_type(bt), .jump_type(jt), .trap_request(trap_request),
    .trap_return(trap_return), .pc(pc_o[2]), .link_address(link_o[2]),
    .taken(taken_o[2]), .busy(busy_o[2]), .epc(epc_o[2]), .cause(cause_o[2]));

  function automatic bit cond_of(logic [2:0] code, logic [31:0] a, logic [31:0] b);
    case (code)
      BRANCH_EQ:  return a == b;
      BRANCH_NE:  return a != b;
      BRANCH_LT:  return $signed(a) <  $signed(b);
      BRANCH_GE:  return $signed(a) >= $signed(b);
      BRANCH_LTU: return a <  b;
      BRANCH_GEU: return a >= b;
      default:    return 1'b0;
    endcase
  endfunction

  // Architectural effect of one clock edge, from the inputs present at that edge.
  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      logic [31:0] tgt;
      bit          redir;
      if (reset) begin
        m_pc[k] = rv[k]; m_link[k] = 0; m_epc[k] = 0; m_cause[k] = 2'd0;
        m_taken[k] = 0; m_wait[k] = 0;
      end else if (trap_request) begin
        m_epc[k] = m_pc[k]; m_cause[k] = 2'd2; m_pc[k] = tv[k];
        m_taken[k] = 1; m_wait[k] = fc[k];
      end else if (trap_return) begin
        m_pc[k] = m_epc[k]; m_cause[k] = 2'd0; m_taken[k] = 1; m_wait[k] = fc[k];
      end else if (m_wait[k] > 0) begin
        m_wait[k]--; m_taken[k] = 0;
      end else if (!step) begin
        m_taken[k] = 0;
      end else begin
        redir = (jt != 2'd0) || cond_of(bt, rs1, rs2);
        tgt   = (jt == 2'd2) ? ((rs1 + imm) & ~32'd1) : (m_pc[k] + imm);
        if (!redir) begin
          m_pc[k] = m_pc[k] + 4; m_taken[k] = 0;
        end else begin
          m_taken[k] = 1; m_wait[k] = fc[k];
          if ((tgt & ((32'd1 << ab[k]) - 1)) == 0) begin
            if (jt != 2'd0) m_link[k] = m_pc[k] + 4;
            m_pc[k] = tgt;
          end else begin
            m_epc[k] = m_pc[k]; m_pc[k] = tv[k]; m_cause[k] = 2'd1;
          end
        end
      end
    end
  endtask

  task automatic cmp(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t got=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      for (int k = 0; k < N; k++) begin
        cmp("pc",    k, pc_o[k],             m_pc[k]);
        cmp("link",  k, link_o[k],           m_link[k]);
        cmp("epc",   k, epc_o[k],            m_epc[k]);
        cmp("cause", k, 32'(cause_o[k]),     32'(m_cause[k]));
        cmp("taken", k, 32'(taken_o[k]),     32'(m_taken[k]));
        cmp("busy",  k, 32'(busy_o[k]),      32'(m_wait[k] > 0));
      end
    end
  end

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lit_%s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic idle_in();
    reset = 0; step = 0; trap_request = 0; trap_return = 0;
    bt = BRANCH_NONE; jt = JUMP_NONE; rs1 = 0; rs2 = 0; imm = 0;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #2;
  endtask

  task automatic rst();
    idle_in(); reset = 1; cyc(); reset = 0;
  endtask

  initial begin
    idle_in();
    reset = 1;
    cyc();
    chk_on = 1;
    lit("rst_pc_a", pc_o[0], 32'h0);
    lit("rst_pc_c", pc_o[2], 32'h200);
    lit("rst_busy", 32'(busy_o[0]), 32'h0);
    lit("rst_cause", 32'(cause_o[0]), 32'h0);
    reset = 0; step = 1;
    cyc(); lit("seq_pc4", pc_o[0], 32'h4);
    cyc(); lit("seq_pc8", pc_o[0], 32'h8);

    bt = BRANCH_LT; rs1 = 32'hFFFF_FFFF; rs2 = 32'h1; imm = 32'd16;
    cyc();
    lit("blt_pc", pc_o[0], 32'd24);
    lit("blt_taken", 32'(taken_o[0]), 32'h1);
    lit("blt_busy", 32'(busy_o[0]), 32'h1);
    bt = BRANCH_NONE;
    cyc();
    lit("blt_hold", pc_o[0], 32'd24);
    lit("blt_busy_end", 32'(busy_o[0]), 32'h0);
    cyc(); lit("blt_resume", pc_o[0], 32'd28);

    rst(); step = 1; cyc(); cyc();
    bt = BRANCH_LTU; rs1 = 32'hFFFF_FFFF; rs2 = 32'h1; imm = 32'd16;
    cyc();
    lit("bltu_pc", pc_o[0], 32'd12);
    lit("bltu_taken", 32'(taken_o[0]), 32'h0);

    rst(); step = 1; jt = JUMP_JAL; imm = 32'h40;
    cyc(); lit("jal_pc", pc_o[0], 32'h40); lit("jal_link", link_o[0], 32'h4);
    idle_in(); repeat (4) cyc();
    step = 1; jt = JUMP_JALR; rs1 = 32'h1001; imm = 32'h2;
    cyc();
    lit("jalr_pc_b", pc_o[1], 32'h1002);
    lit("jalr_link_b", link_o[1], 32'h44);
    lit("jalr_pc_a", pc_o[0], 32'h100);
    lit("jalr_epc_a", epc_o[0], 32'h40);
    lit("jalr_cause_a", 32'(cause_o[0]), 32'(CAUSE_MISALIGNED));
    lit("jalr_link_a", link_o[0], 32'h4);

    rst(); step = 1; jt = JUMP_JAL; imm = 32'h20;
    cyc(); idle_in(); repeat (4) cyc();
    step = 1; trap_request = 1;
    cyc();
    lit("trap_pc", pc_o[0], 32'h100);
    lit("trap_epc", epc_o[0], 32'h20);
    lit("trap_cause", 32'(cause_o[0]), 32'(CAUSE_EXTERNAL));
    idle_in(); repeat (4) cyc();
    trap_return = 1;
    cyc();
    lit("ret_pc", pc_o[0], 32'h20);
    lit("ret_cause", 32'(cause_o[0]), 32'(CAUSE_NONE));
    idle_in(); cyc();

    rst(); step = 1; bt = BRANCH_EQ; rs1 = 5; rs2 = 5; imm = 32'h30;
    cyc(); lit("fl3_pc", pc_o[1], 32'h30); lit("fl3_busy0", 32'(busy_o[1]), 32'h1);
    bt = BRANCH_NONE;
    for (int i = 0; i < 3; i++) begin
      cyc();
      lit("fl3_busy", 32'(busy_o[1]), (i < 2) ? 32'h1 : 32'h0);
      lit("fl3_hold", pc_o[1], 32'h30);
    end
    cyc(); lit("fl3_resume", pc_o[1], 32'h34);

    rst(); step = 1; bt = BRANCH_EQ; rs1 = 5; rs2 = 5; imm = 32'h30;
    cyc(); bt = BRANCH_NONE;
    cyc(); lit("flrst_busy", 32'(busy_o[1]), 32'h1);
    reset = 1;
    cyc();
    lit("flrst_pc", pc_o[1], 32'h0);
    lit("flrst_busy0", 32'(busy_o[1]), 32'h0);
    reset = 0;

    rst(); step = 1; jt = JUMP_JAL; imm = 32'hFFFF_FFFC;
    cyc(); lit("wrap_top", pc_o[0], 32'hFFFF_FFFC);
    idle_in(); repeat (4) cyc();
    step = 1;
    cyc(); lit("wrap_zero", pc_o[0], 32'h0);
    cyc(); lit("wrap_four", pc_o[0], 32'h4);
    bt = BRANCH_EQ; rs1 = 0; rs2 = 0; imm = 32'hFFFF_FFF8;
    cyc(); lit("wrap_back", pc_o[0], 32'hFFFF_FFFC);

    rst();
    for (int c = 0; c < 1500; c++) begin
      int r;
      reset        = ($urandom_range(0, 63) == 0);
      trap_request = ($urandom_range(0, 24) == 0);
      trap_return  = ($urandom_range(0, 24) == 0);
      step         = ($urandom_range(0, 3) != 0);
      bt           = 3'($urandom_range(0, 7));
      r            = $urandom_range(0, 7);
      jt           = (r < 5) ? JUMP_NONE : ((r == 5) ? JUMP_JAL : JUMP_JALR);
      rs1          = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rs2          = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      imm          = (32'($urandom_range(0, 63)) << 2) - 32'd128;
      if ($urandom_range(0, 7) == 0) imm = imm | 32'($urandom_range(1, 3));
      cyc();
    end
    idle_in(); cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
